// File: rtl/rgb_crypt_pkg.sv
// Shared definitions for the RGB stream-cipher blocks (encrypt and decrypt).
//   PIX_W          : bits per colour channel
//   NUM_CH         : channels per pixel (R, G, B)
//   NUM_PIXELS_DEF : default frame size (128x128)
//   dec_state_t    : frame FSM states, reusable by an encrypt-stream FSM
//   rgb_t          : packed pixel, [2]=R, [1]=G, [0]=B
package rgb_crypt_pkg;
  localparam int PIX_W          = 8;
  localparam int NUM_CH         = 3;
  localparam int NUM_PIXELS_DEF = 16384;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dec_state_t;

  typedef logic [NUM_CH-1:0][PIX_W-1:0] rgb_t;
endpackage

// File: rtl/rgb_xor_reg.sv
// Three-channel XOR and output register with valid/ready hold.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture cipher^key and addr_i, raise valid
//   cipher_i     : cipher pixel
//   key_i        : keystream bytes for this pixel
//   addr_i       : pixel index to tag the result with
//   ready_i      : downstream accepts the held pixel
//   valid_o      : plaintext valid
//   plain_o      : plaintext pixel
//   addr_o       : index of plain_o
module rgb_xor_reg
  import rgb_crypt_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  rgb_t              cipher_i,
  input  rgb_t              key_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ready_i,
  output logic              valid_o,
  output rgb_t              plain_o,
  output logic [ADDR_W-1:0] addr_o
);

  rgb_t              plain_q, plain_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;

  // One XOR lane per channel; bytes are independent, no carries.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign plain_d[c] = load_i ? (cipher_i[c] ^ key_i[c]) : plain_q[c];
  end

  assign addr_d = load_i ? addr_i : addr_q;

  // A load wins over an accept, so back-to-back pixels keep valid high.
  always_comb begin
    valid_d = valid_q;
    if (load_i)                  valid_d = 1'b1;
    else if (valid_q && ready_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      plain_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      plain_q <= plain_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign plain_o = plain_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/decrypt_stream.sv
// Receiver-side XOR decryption of an RGB pixel stream.
//   clk, rst                   : clock, synchronous active-high reset
//   start                      : pulse; begins a frame from IDLE or DONE
//   Key_ready, R/G/B_random    : keystream bytes, valid while Key_ready
//   key_advance                : keystream bytes consumed this cycle
//   in_valid/in_ready, R/G/B_cipher : cipher pixel input handshake
//   out_valid/out_ready, R/G/B_plain, pix_addr : plaintext output handshake
//   busy                       : frame in progress (RUN or DRAIN)
//   done                       : frame complete, held until start or rst
// ADDR_W must satisfy 2**ADDR_W >= NUM_PIXELS.
module decrypt_stream
  import rgb_crypt_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int ADDR_W     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              Key_ready,
  input  logic [PIX_W-1:0]  R_random,
  input  logic [PIX_W-1:0]  G_random,
  input  logic [PIX_W-1:0]  B_random,
  output logic              key_advance,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  R_cipher,
  input  logic [PIX_W-1:0]  G_cipher,
  input  logic [PIX_W-1:0]  B_cipher,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  R_plain,
  output logic [PIX_W-1:0]  G_plain,
  output logic [PIX_W-1:0]  B_plain,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              busy,
  output logic              done
);

  dec_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              xfer, last_pix;
  rgb_t              cipher, key, plain;

  assign cipher = {R_cipher, G_cipher, B_cipher};
  assign key    = {R_random, G_random, B_random};

  assign last_pix = (cnt_q == ADDR_W'(NUM_PIXELS - 1));

  // Accept only when the keystream is valid and the output slot is free
  // (or being freed this cycle).
  assign in_ready    = (state_q == RUN) && Key_ready && (!out_valid || out_ready);
  assign xfer        = in_valid && in_ready;
  assign key_advance = xfer;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (xfer) begin
          // Hold the counter on the last pixel so it never wraps in a frame.
          if (last_pix) state_d = DRAIN;
          else          cnt_d   = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (!out_valid || out_ready) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  rgb_xor_reg #(.ADDR_W(ADDR_W)) u_xor (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (xfer),
    .cipher_i (cipher),
    .key_i    (key),
    .addr_i   (cnt_q),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .plain_o  (plain),
    .addr_o   (pix_addr)
  );

  assign R_plain = plain[2];
  assign G_plain = plain[1];
  assign B_plain = plain[0];

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = done_q;

endmodule

// File: tb/tb_decrypt_stream.sv
module tb_decrypt_stream;
  localparam int NP = 5;
  localparam int AW = 3;

  logic          clk, rst, start, Key_ready, in_valid, out_ready;
  logic [7:0]    R_random, G_random, B_random, R_cipher, G_cipher, B_cipher;
  logic          key_advance, in_ready, out_valid, busy, done;
  logic [7:0]    R_plain, G_plain, B_plain;
  logic [AW-1:0] pix_addr;

  decrypt_stream #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .Key_ready(Key_ready),
    .R_random(R_random), .G_random(G_random), .B_random(B_random),
    .key_advance(key_advance), .in_valid(in_valid), .in_ready(in_ready),
    .R_cipher(R_cipher), .G_cipher(G_cipher), .B_cipher(B_cipher),
    .out_valid(out_valid), .out_ready(out_ready),
    .R_plain(R_plain), .G_plain(G_plain), .B_plain(B_plain),
    .pix_addr(pix_addr), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame data: plaintext the transmitter started from, and its keystream.
  logic [23:0] P [NP];
  logic [23:0] K [NP];

  // Reference model: frame-level view of the receiver.
  bit          m_run, m_ov, m_done;
  int          m_n;
  logic [23:0] m_plain;
  logic [AW-1:0] m_addr;
  bit          e_ir, e_xfer;

  task automatic new_frame_data();
    for (int i = 0; i < NP; i++) begin
      P[i] = 24'($urandom);
      K[i] = 24'($urandom);
    end
  endtask

  // Present one cycle of inputs; the keystream source offers the key for the
  // next unconsumed pixel, and the transmitter the matching cipher pixel.
  task automatic drive(input bit st, input bit kr, input bit iv, input bit ordy, input bit rs);
    logic [23:0] k, c;
    @(negedge clk);
    rst = rs; start = st; Key_ready = kr; in_valid = iv; out_ready = ordy;
    k = (kr && m_n < NP) ? K[m_n] : 24'($urandom);
    c = (iv && m_n < NP) ? (P[m_n] ^ K[m_n]) : 24'($urandom);
    {R_random, G_random, B_random} = k;
    {R_cipher, G_cipher, B_cipher} = c;
    e_ir   = m_run && (m_n < NP) && kr && (!m_ov || ordy);
    e_xfer = e_ir && iv;
    #1;
  endtask

  task automatic tick();
    bit run0, ov0;
    int n0;
    @(posedge clk);
    run0 = m_run; ov0 = m_ov; n0 = m_n;
    if (rst) begin
      m_run = 0; m_ov = 0; m_done = 0; m_n = 0; m_plain = '0; m_addr = '0;
    end else begin
      if (e_xfer) begin
        m_ov = 1; m_plain = P[n0]; m_addr = AW'(n0); m_n = n0 + 1;
      end else if (ov0 && out_ready) m_ov = 0;
      if (run0 && n0 == NP && (!ov0 || out_ready)) begin
        m_run = 0; m_done = 1;
      end
      if (!run0 && start) begin
        m_run = 1; m_n = 0; m_done = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 1); tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 1, 1, 1, 0);
    n_tests++;
    if ({out_valid, busy, done, in_ready, key_advance, R_plain, G_plain, B_plain, pix_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ov=%b busy=%b done=%b ir=%b ka=%b plain=%h addr=%0d want all 0",
               out_valid, busy, done, in_ready, key_advance, {R_plain, G_plain, B_plain}, pix_addr);
    end
    tick();
  endtask

  task automatic test_single_pixel();
    do_reset();
    new_frame_data();
    P[0] = 24'h4891A9; K[0] = 24'h5AA5FF;  // cipher presented = 12/34/56
    drive(1, 1, 1, 1, 0);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
    tick();
    drive(0, 1, 1, 1, 0);
    n_tests++;
    if ({in_ready, key_advance} !== 2'b11) begin
      n_fail++; $display("FAIL single_accept got ir=%b ka=%b want 1 1", in_ready, key_advance);
    end
    tick();
    drive(0, 1, 0, 1, 0);
    n_tests++;
    if (out_valid !== 1'b1 || {R_plain, G_plain, B_plain} !== 24'h4891A9 || pix_addr !== '0 || key_advance !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pixel got ov=%b plain=%h addr=%0d ka=%b want 1 4891a9 0 0",
               out_valid, {R_plain, G_plain, B_plain}, pix_addr, key_advance);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int ka_cnt = 0;
    do_reset();
    new_frame_data();
    drive(1, 1, 0, 1, 0); tick();
    for (int c = 0; c <= NP + 2; c++) begin
      drive(0, 1, 1, 1, 0);
      if (key_advance === 1'b1) ka_cnt++;
      n_tests++;
      if (key_advance !== 1'(c < NP) || out_valid !== 1'(c >= 1 && c <= NP) ||
          done !== 1'(c >= NP + 1) || busy !== 1'(c <= NP)) begin
        n_fail++;
        $display("FAIL b2b_ctrl cyc=%0d got ka=%b ov=%b done=%b busy=%b want %b %b %b %b", c,
                 key_advance, out_valid, done, busy, 1'(c < NP), 1'(c >= 1 && c <= NP),
                 1'(c >= NP + 1), 1'(c <= NP));
      end
      if (c >= 1 && c <= NP) begin
        n_tests++;
        if (pix_addr !== AW'(c - 1) || {R_plain, G_plain, B_plain} !== P[c-1]) begin
          n_fail++;
          $display("FAIL b2b_data cyc=%0d got addr=%0d plain=%h want %0d %h", c, pix_addr,
                   {R_plain, G_plain, B_plain}, c - 1, P[c-1]);
        end
      end
      tick();
    end
    n_tests++;
    if (ka_cnt != NP) begin n_fail++; $display("FAIL b2b_key_pulses got %0d want %0d", ka_cnt, NP); end
  endtask

  task automatic test_backpressure();
    int exp_a = 0;
    int cyc = 0;
    do_reset();
    new_frame_data();
    drive(1, 1, 0, 1, 0); tick();
    drive(0, 1, 1, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0);
      n_tests++;
      if (in_ready !== 1'b0 || key_advance !== 1'b0 || out_valid !== 1'b1 ||
          pix_addr !== '0 || {R_plain, G_plain, B_plain} !== P[0]) begin
        n_fail++;
        $display("FAIL bp_hold i=%0d got ir=%b ka=%b ov=%b addr=%0d plain=%h want 0 0 1 0 %h", i,
                 in_ready, key_advance, out_valid, pix_addr, {R_plain, G_plain, B_plain}, P[0]);
      end
      tick();
    end
    while (!m_done && cyc < 40) begin
      drive(0, 1, 1, 1, 0);
      if (out_valid === 1'b1) begin
        n_tests++;
        if (exp_a >= NP || pix_addr !== AW'(exp_a) || {R_plain, G_plain, B_plain} !== P[exp_a]) begin
          n_fail++;
          $display("FAIL bp_resume got addr=%0d plain=%h want addr %0d", pix_addr,
                   {R_plain, G_plain, B_plain}, exp_a);
        end
        exp_a++;
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (exp_a != NP || !m_done) begin
      n_fail++; $display("FAIL bp_count got %0d outputs want %0d", exp_a, NP);
    end
  endtask

  task automatic test_key_stall();
    do_reset();
    new_frame_data();
    drive(1, 1, 0, 1, 0); tick();
    for (int i = 0; i < 2; i++) begin drive(0, 1, 1, 1, 0); tick(); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 0);
      n_tests++;
      if (in_ready !== 1'b0 || key_advance !== 1'b0) begin
        n_fail++; $display("FAIL stall i=%0d got ir=%b ka=%b want 0 0", i, in_ready, key_advance);
      end
      if (i == 1) begin
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got ov=%b want 0", out_valid); end
      end
      tick();
    end
    drive(0, 1, 1, 1, 0);
    n_tests++;
    if (key_advance !== 1'b1) begin n_fail++; $display("FAIL stall_resume got ka=%b want 1", key_advance); end
    tick();
    drive(0, 1, 0, 1, 0);
    n_tests++;
    if (pix_addr !== AW'(2) || {R_plain, G_plain, B_plain} !== P[2]) begin
      n_fail++;
      $display("FAIL stall_data got addr=%0d plain=%h want 2 %h", pix_addr, {R_plain, G_plain, B_plain}, P[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    new_frame_data();
    drive(1, 1, 0, 1, 0); tick();
    for (int i = 0; i < 2; i++) begin drive(0, 1, 1, 1, 0); tick(); end
    drive(0, 1, 1, 1, 1); tick();
    drive(0, 0, 0, 0, 0);
    n_tests++;
    if ({out_valid, busy, done, in_ready, key_advance, R_plain, G_plain, B_plain, pix_addr} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs got ov=%b busy=%b done=%b plain=%h addr=%0d want all 0",
               out_valid, busy, done, {R_plain, G_plain, B_plain}, pix_addr);
    end
    tick();
    new_frame_data();
    drive(1, 1, 0, 1, 0); tick();
    drive(0, 1, 1, 1, 0); tick();
    drive(0, 1, 0, 1, 0);
    n_tests++;
    if (out_valid !== 1'b1 || pix_addr !== '0 || {R_plain, G_plain, B_plain} !== P[0]) begin
      n_fail++;
      $display("FAIL midrst_restart got ov=%b addr=%0d plain=%h want 1 0 %h", out_valid, pix_addr,
               {R_plain, G_plain, B_plain}, P[0]);
    end
    tick();
  endtask

  // Several frames back to back (restarting from DONE) with random handshakes,
  // key stalls and stray start pulses, checked cycle by cycle against the model.
  task automatic test_random_round_trip();
    do_reset();
    for (int f = 0; f < 6; f++) begin
      int cyc = 0;
      new_frame_data();
      drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      tick();
      while (cyc < 400) begin
        bit st, kr, iv, ordy;
        st   = m_run && ($urandom_range(0, 9) == 0);
        kr   = ($urandom_range(0, 9) < 8);
        iv   = ($urandom_range(0, 9) < 7);
        ordy = ($urandom_range(0, 9) < 7);
        drive(st, kr, iv, ordy, 0);
        n_tests++;
        if (in_ready !== e_ir || key_advance !== e_xfer || busy !== m_run ||
            done !== m_done || out_valid !== m_ov ||
            (m_ov && (pix_addr !== m_addr || {R_plain, G_plain, B_plain} !== m_plain))) begin
          n_fail++;
          $display("FAIL rand f=%0d cyc=%0d got ir=%b ka=%b busy=%b done=%b ov=%b addr=%0d plain=%h want %b %b %b %b %b %0d %h",
                   f, cyc, in_ready, key_advance, busy, done, out_valid, pix_addr,
                   {R_plain, G_plain, B_plain}, e_ir, e_xfer, m_run, m_done, m_ov, m_addr, m_plain);
        end
        tick();
        cyc++;
        if (m_done && cyc > 1) begin
          drive(0, 1, 0, 1, 0);
          n_tests++;
          if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rand_done f=%0d got done=%b busy=%b want 1 0", f, done, busy);
          end
          tick();
          break;
        end
      end
      if (!m_done) begin
        n_tests++; n_fail++;
        $display("FAIL rand_timeout f=%0d frame did not complete in budget", f);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; Key_ready = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    {R_random, G_random, B_random, R_cipher, G_cipher, B_cipher} = '0;
    m_run = 0; m_ov = 0; m_done = 0; m_n = 0; m_plain = '0; m_addr = '0;
    e_ir = 0; e_xfer = 0;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_backpressure();
    test_key_stall();
    test_reset_mid();
    test_random_round_trip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
